// File: rtl/ps2_keyboard_rx.sv
// PS/2 set-2 keyboard receiver: deserialises frames and tracks E0/F0 prefixes into a held-key level.
// Optional mid-frame idle timeout is compiled in with PS2_TIMEOUT_EN.
module ps2_keyboard_rx #(
  parameter int TIMEOUT_CYCLES = 100000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       ps2_clk,
  input  logic       ps2_data,
  output logic       keypress,
  output logic [7:0] keycode,
  output logic       extended,
  output logic       code_valid,
  output logic       frame_err
);

  typedef enum logic [1:0] {IDLE, DATA, PARITY, STOP} state_t;

  state_t     state;
  logic [1:0] clk_sync, data_sync;
  logic       clk_prev;
  logic [7:0] shift;
  logic [2:0] bit_cnt;
  logic       par_bit;
  logic       ext_f, brk_f;
  logic       fall;
  logic       ignored;

  assign fall    = clk_prev & ~clk_sync[1];
  // Keyboard ack/BAT/echo/resend/error bytes never describe a key.
  assign ignored = (shift == 8'hFA) || (shift == 8'hAA) || (shift == 8'hEE) ||
                   (shift == 8'hFE) || (shift == 8'hFC) || (shift == 8'h00) ||
                   (shift == 8'hFF);

`ifdef PS2_TIMEOUT_EN
  localparam int TO_W = $clog2(TIMEOUT_CYCLES + 1);
  logic [TO_W-1:0] to_cnt;
`else
  logic unused_timeout;
  assign unused_timeout = (TIMEOUT_CYCLES != 0);
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      clk_sync   <= 2'b11;
      data_sync  <= 2'b11;
      clk_prev   <= 1'b1;
      state      <= IDLE;
      shift      <= 8'h00;
      bit_cnt    <= 3'd0;
      par_bit    <= 1'b0;
      ext_f      <= 1'b0;
      brk_f      <= 1'b0;
      keypress   <= 1'b0;
      keycode    <= 8'h00;
      extended   <= 1'b0;
      code_valid <= 1'b0;
      frame_err  <= 1'b0;
`ifdef PS2_TIMEOUT_EN
      to_cnt     <= '0;
`endif
    end else begin
      clk_sync   <= {clk_sync[0], ps2_clk};
      data_sync  <= {data_sync[0], ps2_data};
      clk_prev   <= clk_sync[1];
      code_valid <= 1'b0;
      frame_err  <= 1'b0;
      if (fall) begin
        case (state)
          IDLE: if (!data_sync[1]) begin
            state   <= DATA;
            bit_cnt <= 3'd0;
          end
          DATA: begin
            shift   <= {data_sync[1], shift[7:1]};
            bit_cnt <= bit_cnt + 3'd1;
            if (bit_cnt == 3'd7) state <= PARITY;
          end
          PARITY: begin
            par_bit <= data_sync[1];
            state   <= STOP;
          end
          STOP: begin
            state <= IDLE;
            if (data_sync[1] && (^{shift, par_bit})) begin
              code_valid <= 1'b1;
              if (shift == 8'hE0) begin
                ext_f <= 1'b1;
              end else if (shift == 8'hF0) begin
                brk_f <= 1'b1;
              end else begin
                ext_f <= 1'b0;
                brk_f <= 1'b0;
                if (ignored) begin
                  // flags cleared, outputs untouched
                end else if (brk_f) begin
                  // Only releasing the key currently reported drops keypress.
                  if (shift == keycode && ext_f == extended) keypress <= 1'b0;
                end else begin
                  keycode  <= shift;
                  extended <= ext_f;
                  keypress <= 1'b1;
                end
              end
            end else begin
              frame_err <= 1'b1;
            end
          end
          default: state <= IDLE;
        endcase
      end
`ifdef PS2_TIMEOUT_EN
      // Edges and timeout are mutually exclusive, so the state override cannot collide.
      if (fall) begin
        to_cnt <= '0;
      end else if (state != IDLE) begin
        if (to_cnt == TO_W'(TIMEOUT_CYCLES)) begin
          state     <= IDLE;
          frame_err <= 1'b1;
          to_cnt    <= '0;
        end else begin
          to_cnt <= to_cnt + 1'b1;
        end
      end
`endif
    end
  end

endmodule

// File: tb/tb_ps2_keyboard_rx.sv
// Scoreboard bench for ps2_keyboard_rx: directed PS/2 frames with hand-written expected key state.
module tb_ps2_keyboard_rx;

  logic       clk, rst, ps2_clk, ps2_data;
  logic       keypress, extended, code_valid, frame_err;
  logic [7:0] keycode;

  ps2_keyboard_rx #(.TIMEOUT_CYCLES(100)) dut (
    .clk(clk), .rst(rst), .ps2_clk(ps2_clk), .ps2_data(ps2_data),
    .keypress(keypress), .keycode(keycode), .extended(extended),
    .code_valid(code_valid), .frame_err(frame_err)
  );

  typedef struct {
    bit         err;
    bit         kp;
    logic [7:0] kc;
    bit         ext;
  } ev_t;

  ev_t exp_q[$];
  int  checks = 0;
  int  errors = 0;
  bit  hold_high = 0;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Monitor: every code_valid/frame_err pulse consumes one expected event.
  always @(negedge clk) begin
    if (!rst) begin
      if (code_valid || frame_err) begin
        ev_t e;
        checks++;
        if (code_valid && frame_err) begin
          errors++;
          $display("FAIL both_pulses code_valid=%b frame_err=%b, required not both", code_valid, frame_err);
        end else if (exp_q.size() == 0) begin
          errors++;
          $display("FAIL unexpected_event code_valid=%b frame_err=%b kp=%b kc=%h ext=%b",
                   code_valid, frame_err, keypress, keycode, extended);
        end else begin
          e = exp_q.pop_front();
          if (frame_err != e.err || keypress != e.kp || keycode != e.kc || extended != e.ext) begin
            errors++;
            $display("FAIL event got err=%b kp=%b kc=%h ext=%b, required err=%b kp=%b kc=%h ext=%b",
                     frame_err, keypress, keycode, extended, e.err, e.kp, e.kc, e.ext);
          end
        end
      end
      if (hold_high) begin
        checks++;
        if (!keypress) begin
          errors++;
          $display("FAIL typematic_glitch keypress=%b, required 1", keypress);
        end
      end
    end
  end

  task automatic expect_ev(input bit err, input bit kp, input logic [7:0] kc, input bit ext);
    ev_t e;
    e.err = err; e.kp = kp; e.kc = kc; e.ext = ext;
    exp_q.push_back(e);
  endtask

  task automatic ps2_bit(input logic v);
    ps2_data = v;
    repeat (5) @(posedge clk);
    #1 ps2_clk = 1'b0;
    repeat (10) @(posedge clk);
    #1 ps2_clk = 1'b1;
    repeat (5) @(posedge clk);
    #1;
  endtask

  task automatic frame_bits(input logic [7:0] b, input bit bad_par, input bit bad_stop,
                            input int first, input int last);
    logic [10:0] f;
    f = {~bad_stop, (~^b) ^ bad_par, b, 1'b0};
    for (int i = first; i <= last; i++) ps2_bit(f[i]);
    ps2_data = 1'b1;
  endtask

  task automatic send(input logic [7:0] b, input bit kp, input logic [7:0] kc, input bit ext);
    expect_ev(1'b0, kp, kc, ext);
    frame_bits(b, 1'b0, 1'b0, 0, 10);
  endtask

  task automatic wait_drain();
    int n = 0;
    while (exp_q.size() != 0 && n < 3000) begin
      @(posedge clk);
      n++;
    end
    repeat (4) @(posedge clk);
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL drain_timeout pending=%0d, required 0", exp_q.size());
      exp_q.delete();
    end
  endtask

  task automatic check_state(input string name, input bit kp, input logic [7:0] kc, input bit ext);
    @(negedge clk);
    checks++;
    if (keypress != kp || keycode != kc || extended != ext || code_valid || frame_err) begin
      errors++;
      $display("FAIL %s got kp=%b kc=%h ext=%b cv=%b fe=%b, required kp=%b kc=%h ext=%b cv=0 fe=0",
               name, keypress, keycode, extended, code_valid, frame_err, kp, kc, ext);
    end
  endtask

  initial begin
    rst = 1'b1; ps2_clk = 1'b1; ps2_data = 1'b1;
    repeat (4) @(posedge clk);
    #1 rst = 1'b0;
    check_state("reset", 1'b0, 8'h00, 1'b0);

    // 1: single make
    send(8'h0D, 1, 8'h0D, 0);
    wait_drain();
    check_state("make_0d", 1'b1, 8'h0D, 1'b0);

    // 2: typematic repeats then release
    hold_high = 1;
    send(8'h0D, 1, 8'h0D, 0);
    send(8'h0D, 1, 8'h0D, 0);
    send(8'h0D, 1, 8'h0D, 0);
    send(8'hF0, 1, 8'h0D, 0);
    wait_drain();
    hold_high = 0;
    send(8'h0D, 0, 8'h0D, 0);
    wait_drain();

    // 3: second key while first held; releasing the old key is ignored
    send(8'h0D, 1, 8'h0D, 0);
    send(8'h15, 1, 8'h15, 0);
    send(8'hF0, 1, 8'h15, 0);
    send(8'h0D, 1, 8'h15, 0);
    send(8'hF0, 1, 8'h15, 0);
    send(8'h15, 0, 8'h15, 0);
    wait_drain();

    // 4: extended make; non-extended break of same code ignored
    send(8'hE0, 0, 8'h15, 0);
    send(8'h5A, 1, 8'h5A, 1);
    send(8'hF0, 1, 8'h5A, 1);
    send(8'h5A, 1, 8'h5A, 1);
    send(8'hE0, 1, 8'h5A, 1);
    send(8'hF0, 1, 8'h5A, 1);
    send(8'h5A, 0, 8'h5A, 1);
    wait_drain();

    // 5: framing errors, an ignored byte, reset mid-frame
    expect_ev(1'b1, 0, 8'h5A, 1);
    frame_bits(8'h15, 1'b1, 1'b0, 0, 10);
    expect_ev(1'b1, 0, 8'h5A, 1);
    frame_bits(8'h1C, 1'b0, 1'b1, 0, 10);
    send(8'hAA, 0, 8'h5A, 1);
    wait_drain();
    check_state("after_errors", 1'b0, 8'h5A, 1'b1);
    send(8'hE0, 0, 8'h5A, 1);
    wait_drain();
    frame_bits(8'h77, 1'b0, 1'b0, 0, 4);
    @(posedge clk);
    #1 rst = 1'b1;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    check_state("mid_frame_reset", 1'b0, 8'h00, 1'b0);
    send(8'h24, 1, 8'h24, 0);
    wait_drain();

    // 6: stall after 4 data bits
    frame_bits(8'h33, 1'b0, 1'b0, 0, 4);
`ifdef PS2_TIMEOUT_EN
    expect_ev(1'b1, 1, 8'h24, 0);
    repeat (150) @(posedge clk);
    #1;
`else
    repeat (150) @(posedge clk);
    #1;
    expect_ev(1'b0, 1, 8'h33, 0);
    frame_bits(8'h33, 1'b0, 1'b0, 5, 10);
`endif
    wait_drain();
    send(8'h1C, 1, 8'h1C, 0);
    send(8'h24, 1, 8'h24, 0);
    wait_drain();
    check_state("final", 1'b1, 8'h24, 1'b0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
